seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Multi-digit, time-multiplexed 7-segment display controller. It accepts a binary value over a load/ready handshake and converts it to BCD sequentially, using shift-and-add-3 at one bit per cycle. The converted digits are committed atomically to a display register, which is scanned across `NUM_DIGITS` common-anode digits with leading-zero blanking, an overflow indication and per-digit decimal points. It replaces the per-digit combinational segment drivers at the top of the display path.

## Interface
- `NUM_DIGITS`, 4: number of display digits; legal range 1..8.
- `BIN_W`, 14: width of the binary input; legal range 4..27.
- `SCAN_DIV`, 50000: clock cycles each digit is driven per scan step; must be ≥ 2.
- `clk` input 1: the single clock; all state is on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load` input 1: request to convert `bin_in`; accepted only while `ready`=1.
- `bin_in` input BIN_W: unsigned value, sampled on an accepted load.
- `dp_in` input NUM_DIGITS: decimal-point enables, sampled with `bin_in`; bit i controls digit i, 1 = lit.
- `ready` output 1: converter idle; a load is accepted this cycle.
- `overflow` output 1: the committed value exceeds 10^NUM_DIGITS − 1.
- `digit_sel` output NUM_DIGITS: active-low, one-hot digit enable; bit 0 is the least significant digit.
- `seg_out` output 8: active-low segments `{dp,g,f,e,d,c,b,a}`; 1 = off.

## Operation
- **Segment codes** (bits 6:0, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111, dash = 0111111.
  - BCD codes 10–15 cannot occur; if they do, drive blank.
- **Converter FSM states:** IDLE → CONV → COMMIT → IDLE.
- **IDLE:**
  - `ready`=1.
  - On `load`: capture `bin_in` and `dp_in`, clear the BCD accumulator, latch `ovf_pend = (bin_in > 10^NUM_DIGITS − 1)`, then go to CONV.
- **CONV:**
  - Runs exactly BIN_W cycles.
  - Each cycle: add 3 to every BCD nibble ≥ 5, then shift the accumulator left by one, taking in the binary MSB.
  - The accumulator is NUM_DIGITS×4 bits; its contents are don't-care when `ovf_pend` is set.
- **COMMIT:**
  - Single cycle. Copies the BCD digits, dp mask and `ovf_pend` into the display register, and sets `disp_valid`.
  - Next state is IDLE.
- `load` while `ready`=0 is ignored; nothing is queued.
- The display register changes only in COMMIT, so the scanned output never shows a partial conversion.
- **Leading-zero blanking:**
  - Digit i is blank if it and every digit above it are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Decimal points are independent of blanking.
- **Overflow:** every digit shows dash, decimal points are off, and `overflow`=1 until the next commit.
- **Not valid** (`disp_valid`=0, i.e. after reset before the first commit): every digit shows blank with dp off.
- **Scan:**
  - `scan_cnt` counts 0..SCAN_DIV−1.
  - On wrap, `digit_idx` advances by 1 modulo NUM_DIGITS (wraps from NUM_DIGITS−1 to 0).
  - The scan is free-running and independent of the converter.

## Timing
- **Reset values:**
  - FSM = IDLE, `ready`=1, `overflow`=0.
  - `scan_cnt`=0, `digit_idx`=0.
  - `digit_sel` = ~1 (digit 0 enabled), `seg_out`=8'hFF, `disp_valid`=0.
- **Latency:**
  - A load accepted at edge T gives CONV edges T+1..T+BIN_W.
  - COMMIT is at edge T+BIN_W+1; `ready`=1 again after that edge.
  - Load-to-load throughput is BIN_W+2 cycles.
- **Output registration:**
  - `digit_sel` and `seg_out` are registered, one cycle behind `digit_idx` and the display register, and always change on the same edge.
  - `overflow` is registered and updates at the COMMIT edge.
- **Simultaneous events:** a scan wrap on the same edge as COMMIT uses the new display data at the next `digit_idx` one cycle later; no glitch mixes old and new data within one digit slot except for that single-cycle boundary.
- **Reset mid-conversion:** the conversion is aborted, the display returns to blank, and the FSM returns to IDLE.

## Structure
- Package `seg_pkg` holds:
  - `SEG_BLANK`, `SEG_DASH` and the BCD-to-segment function.
  - The FSM state enum `conv_state_t`.
  - `pow10_m1(NUM_DIGITS)`, the constant function computing 10^NUM_DIGITS − 1.
- Sub-module `bin2bcd_seq` contains the converter FSM and accumulator, with ports `start`/`ready`/`done` and BCD out.
- The top level holds:
  - the display register and blanking logic;
  - the scan counter and the output registers.

## Test plan
All scenarios use NUM_DIGITS=4, BIN_W=14, SCAN_DIV=4.
- **Reset:** release reset → `seg_out`=8'hFF on every digit slot, `ready`=1, `overflow`=0, and `digit_sel` rotates 1110→1101→1011→0111→1110, 4 cycles each.
- **Normal value:**
  - Stimulus: load 1234 with `dp_in`=0100.
  - `ready` is low for exactly 15 cycles after the load.
  - Expected `seg_out` per digit: d0 = 8'b10011001, d1 = 8'b10110000, d2 = 8'b00100100 (dp lit), d3 = 8'b11111001.
- **Leading-zero blanking:**
  - Load 7 → d0 = 8'b11111000, d1–d3 = 8'hFF.
  - Load 0 → d0 = 8'b11000000, others 8'hFF.
- **Overflow:**
  - Load 12000 → `overflow`=1 and all digits = 8'b10111111.
  - Then load 9999 → `overflow`=0 and all digits = 8'b10010000.
- **Load ignored while busy:** load 42, then load 9 on the 3rd cycle after acceptance → the display shows 42 and the FSM returns to IDLE only once.
- **Reset mid-conversion:** assert `rst_n`=0 on the 5th CONV cycle → all reset values restored and the display blank.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment codes, converter states and constant helpers
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } conv_state_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles fall back to blank.
  function automatic logic [6:0] bcd2seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic int unsigned pow10_m1(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    ready,
  output logic                    done,
  output logic                    ovf,
  output logic [NUM_DIGITS*4-1:0] bcd
);

  localparam int          ACC_W   = NUM_DIGITS * 4;
  localparam int          CNT_W   = $clog2(BIN_W);
  localparam logic [31:0] MAX_VAL = 32'(pow10_m1(NUM_DIGITS));

  conv_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIN_W-1:0] shift_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic             ready_q;
  logic             done_q;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    acc_d = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_q <= bin;
            acc_q   <= '0;
            ovf_q   <= 32'(bin) > MAX_VAL;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc_q   <= acc_d;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            state_q <= ST_COMMIT;
            done_q  <= 1'b1;
          end
        end
        ST_COMMIT: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign bcd   = acc_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - multiplexed 7-segment display with atomic commit,
// leading-zero blanking, overflow dashes and per-digit decimal points
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic                  ready,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [7:0]            seg_out
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic                    conv_ready;
  logic                    conv_done;
  logic                    conv_ovf;
  logic [NUM_DIGITS*4-1:0] conv_bcd;

  logic [NUM_DIGITS-1:0]   dp_pend_q;
  logic                    disp_valid_q;
  logic                    disp_ovf_q;
  logic [NUM_DIGITS*4-1:0] disp_bcd_q;
  logic [NUM_DIGITS-1:0]   disp_dp_q;
  logic [SCAN_W-1:0]       scan_cnt_q;
  logic [IDX_W-1:0]        digit_idx_q;
  logic [NUM_DIGITS-1:0]   digit_sel_q;
  logic [NUM_DIGITS-1:0]   digit_sel_d;
  logic [7:0]              seg_q;
  logic [7:0]              seg_d;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              cur_nib;
  logic                    any_nz;

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .BIN_W     (BIN_W)
  ) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(load),
    .bin  (bin_in),
    .ready(conv_ready),
    .done (conv_done),
    .ovf  (conv_ovf),
    .bcd  (conv_bcd)
  );

  // Display register only moves on the converter's commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_pend_q    <= '0;
      disp_valid_q <= 1'b0;
      disp_ovf_q   <= 1'b0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
    end else begin
      if (load && conv_ready) dp_pend_q <= dp_in;
      if (conv_done) begin
        disp_valid_q <= 1'b1;
        disp_ovf_q   <= conv_ovf;
        disp_bcd_q   <= conv_bcd;
        disp_dp_q    <= dp_pend_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // A digit blanks when it and everything above it are zero; digit 0 never blanks.
  always_comb begin
    any_nz     = 1'b0;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any_nz        = any_nz | (disp_bcd_q[i*4 +: 4] != 4'd0);
      blank_mask[i] = !any_nz && (i != 0);
    end
    cur_nib     = disp_bcd_q[{digit_idx_q, 2'b00} +: 4];
    digit_sel_d = ~(NUM_DIGITS'(1) << digit_idx_q);
    seg_d       = 8'hFF;
    if (disp_valid_q) begin
      if (disp_ovf_q) begin
        seg_d = {1'b1, SEG_DASH};
      end else begin
        seg_d = {~disp_dp_q[digit_idx_q],
                 blank_mask[digit_idx_q] ? SEG_BLANK : bcd2seg(cur_nib)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_q <= ~NUM_DIGITS'(1);
      seg_q       <= 8'hFF;
    end else begin
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign ready     = conv_ready;
  assign overflow  = disp_ovf_q;
  assign digit_sel = digit_sel_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - directed self-checking bench for seg_display_ctrl
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] bin_in = '0;
  logic [3:0]  dp_in = '0;
  logic        ready;
  logic        overflow;
  logic [3:0]  digit_sel;
  logic [7:0]  seg_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .NUM_DIGITS(4),
    .BIN_W     (14),
    .SCAN_DIV  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .bin_in   (bin_in),
    .dp_in    (dp_in),
    .ready    (ready),
    .overflow (overflow),
    .digit_sel(digit_sel),
    .seg_out  (seg_out)
  );

  task automatic do_load(input logic [13:0] v, input logic [3:0] dp);
    @(negedge clk);
    load = 1'b1; bin_in = v; dp_in = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_display(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_seg [4];
    logic [3:0] seen;
    int idx;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    seen = '0;
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (digit_sel)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      total++;
      if (idx < 0) begin
        bad++;
        $display("FAIL %s digit_sel got %b want one-hot-low", name, digit_sel);
      end else begin
        seen[idx] = 1'b1;
        total++;
        if (seg_out !== exp_seg[idx]) begin
          bad++;
          $display("FAIL %s d%0d seg_out got %b want %b", name, idx, seg_out, exp_seg[idx]);
        end
      end
    end
    total++;
    if (seen !== 4'hF) begin
      bad++;
      $display("FAIL %s digits_seen got %b want 1111", name, seen);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset;
    logic [3:0] one;
    logic [3:0] exp_sel;
    one = 4'b0001;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_ready", ready, 1'b1);
    check_bit("reset_overflow", overflow, 1'b0);
    total++;
    if (seg_out !== 8'hFF || digit_sel !== 4'b1110) begin
      bad++;
      $display("FAIL reset_outputs got seg=%h sel=%b want seg=ff sel=1110", seg_out, digit_sel);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_sel = ~(one << (((k - 1) / 4) % 4));
      total++;
      if (digit_sel !== exp_sel || seg_out !== 8'hFF) begin
        bad++;
        $display("FAIL reset_scan k=%0d got sel=%b seg=%h want sel=%b seg=ff", k, digit_sel, seg_out, exp_sel);
      end
    end
    check_bit("reset_ready_after", ready, 1'b1);
  endtask

  task automatic test_normal;
    int n;
    do_load(14'd1234, 4'b0100);
    wait_ready(n);
    total++;
    if (n != 15) begin
      bad++;
      $display("FAIL normal_busy_cycles got %0d want 15", n);
    end
    check_bit("normal_overflow", overflow, 1'b0);
    check_display("normal_1234", 8'b10011001, 8'b10110000, 8'b00100100, 8'b11111001);
  endtask

  task automatic test_blanking;
    int n;
    do_load(14'd7, 4'b0000);
    wait_ready(n);
    check_display("blank_7", 8'b11111000, 8'hFF, 8'hFF, 8'hFF);
    do_load(14'd0, 4'b0000);
    wait_ready(n);
    check_display("blank_0", 8'b11000000, 8'hFF, 8'hFF, 8'hFF);
  endtask

  task automatic test_back_to_back;
    int lows;
    int rises;
    logic prev;
    lows = 0; rises = 0;
    @(negedge clk);
    load = 1'b1; bin_in = 14'd42; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    prev = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (ready === 1'b0) lows++;
      if (ready === 1'b1 && prev === 1'b0) rises++;
      prev = ready;
      if (c == 2) begin
        load = 1'b1; bin_in = 14'd9;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (lows != 15) begin
      bad++;
      $display("FAIL busy_low_cycles got %0d want 15", lows);
    end
    total++;
    if (rises != 1) begin
      bad++;
      $display("FAIL busy_idle_returns got %0d want 1", rises);
    end
    check_display("busy_42", 8'b10100100, 8'b10011001, 8'hFF, 8'hFF);
  endtask

  task automatic test_overflow;
    int n;
    do_load(14'd12000, 4'b1111);
    wait_ready(n);
    @(negedge clk);
    check_bit("ovf_set", overflow, 1'b1);
    check_display("ovf_12000", 8'b10111111, 8'b10111111, 8'b10111111, 8'b10111111);
    do_load(14'd9999, 4'b0000);
    wait_ready(n);
    @(negedge clk);
    check_bit("ovf_clear_9999", overflow, 1'b0);
    check_display("max_9999", 8'b10010000, 8'b10010000, 8'b10010000, 8'b10010000);
  endtask

  task automatic test_reset_midconv;
    int n;
    do_load(14'd12000, 4'b0000);
    wait_ready(n);
    @(negedge clk);
    check_bit("midrst_pre_ovf", overflow, 1'b1);
    do_load(14'd1234, 4'b0000);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_ready", ready, 1'b1);
    check_bit("midrst_overflow", overflow, 1'b0);
    total++;
    if (seg_out !== 8'hFF || digit_sel !== 4'b1110) begin
      bad++;
      $display("FAIL midrst_outputs got seg=%h sel=%b want seg=ff sel=1110", seg_out, digit_sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_display("midrst_blank", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check_bit("midrst_ready_after", ready, 1'b1);
    check_bit("midrst_ovf_after", overflow, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_blanking();
    test_back_to_back();
    test_overflow();
    test_reset_midconv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
